// File: rtl/decode_pkg.sv
// Shared types and encodings for the decode stage: RV32 opcodes, ALUOp classes
// and the per-slot decoded record held in the output buffer.
package decode_pkg;

   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;

   localparam logic [2:0] AluMem    = 3'b000;
   localparam logic [2:0] AluBranch = 3'b001;
   localparam logic [2:0] AluReg    = 3'b010;
   localparam logic [2:0] AluImm    = 3'b011;
   localparam logic [2:0] AluLui    = 3'b100;
   localparam logic [2:0] AluAuipc  = 3'b101;
   localparam logic [2:0] AluJalr   = 3'b110;
   localparam logic [2:0] AluJal    = 3'b111;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [2:0] aluop;
      logic [6:0] opcode;
      logic       fu_alu;
      logic       fu_mem;
      logic       uses_rs1;
      logic       uses_rs2;
      logic       writes_rd;
      logic       illegal;
   } decoded_slot_t;

   localparam int unsigned SlotBits = $bits(decoded_slot_t);

endpackage

// File: rtl/slot_decoder.sv
// Combinational decode of one RV32 instruction slot into a decoded_slot_t record.
// Invalid slots produce an all-zero record; unknown opcodes only raise illegal.
module slot_decoder
   import decode_pkg::*;
#(
   parameter int unsigned EXT_JUMPS = 0
) (
   input  logic [31:0]         i_instr,
   input  logic                i_valid,
   output logic [SlotBits-1:0] o_slot
);

   decoded_slot_t w_dec;
   logic          w_legal;
   logic          w_use_rs1;
   logic          w_use_rs2;
   logic          w_use_rd;
   logic          w_mem;
   logic [2:0]    w_aluop;
   logic          w_unused;

   // funct3/funct7 do not affect this stage's outputs
   assign w_unused = ^{i_instr[31:25], i_instr[14:12]};

   always_comb begin
      w_legal   = 1'b1;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_use_rd  = 1'b0;
      w_mem     = 1'b0;
      w_aluop   = AluMem;
      case (i_instr[6:0])
         OpcOpImm:  begin w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_aluop = AluImm; end
         OpcLui:    begin w_use_rd = 1'b1; w_aluop = AluLui; end
         OpcOp:     begin
            w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; w_aluop = AluReg;
         end
         OpcLoad:   begin w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_mem = 1'b1; end
         OpcStore:  begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_mem = 1'b1; end
         OpcBranch: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_aluop = AluBranch; end
         OpcJalr:   begin w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_aluop = AluJalr; end
         OpcAuipc:  begin w_legal = (EXT_JUMPS != 0); w_use_rd = 1'b1; w_aluop = AluAuipc; end
         OpcJal:    begin w_legal = (EXT_JUMPS != 0); w_use_rd = 1'b1; w_aluop = AluJal; end
         default:   w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_dec = '0;
      if (i_valid) begin
         if (w_legal) begin
            w_dec.rs1       = w_use_rs1 ? i_instr[19:15] : 5'd0;
            w_dec.rs2       = w_use_rs2 ? i_instr[24:20] : 5'd0;
            w_dec.rd        = w_use_rd  ? i_instr[11:7]  : 5'd0;
            w_dec.aluop     = w_aluop;
            w_dec.opcode    = i_instr[6:0];
            w_dec.fu_alu    = 1'b1;
            w_dec.fu_mem    = w_mem;
            w_dec.uses_rs1  = w_use_rs1;
            w_dec.uses_rs2  = w_use_rs2;
            w_dec.writes_rd = w_use_rd && (i_instr[11:7] != 5'd0);
         end else begin
            w_dec.illegal   = 1'b1;
         end
      end
   end

   assign o_slot = w_dec;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes a bundle of DECODE_WIDTH slots and holds decoded
// bundles in a 2-entry FIFO so in_ready depends only on registered state.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned DECODE_WIDTH = 2,
   parameter int unsigned EXT_JUMPS    = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_flush,
   input  logic                      i_in_valid,
   output logic                      o_in_ready,
   input  logic [32*DECODE_WIDTH-1:0] i_in_instr,
   input  logic [DECODE_WIDTH-1:0]   i_in_slot_valid,
   input  logic [31:0]               i_in_pc,
   output logic                      o_out_valid,
   input  logic                      i_out_ready,
   output logic [DECODE_WIDTH-1:0]   o_out_slot_valid,
   output logic [5*DECODE_WIDTH-1:0] o_out_rs1,
   output logic [5*DECODE_WIDTH-1:0] o_out_rs2,
   output logic [5*DECODE_WIDTH-1:0] o_out_rd,
   output logic [3*DECODE_WIDTH-1:0] o_out_aluop,
   output logic [7*DECODE_WIDTH-1:0] o_out_opcode,
   output logic [DECODE_WIDTH-1:0]   o_out_fu_alu,
   output logic [DECODE_WIDTH-1:0]   o_out_fu_mem,
   output logic [DECODE_WIDTH-1:0]   o_out_uses_rs1,
   output logic [DECODE_WIDTH-1:0]   o_out_uses_rs2,
   output logic [DECODE_WIDTH-1:0]   o_out_writes_rd,
   output logic [DECODE_WIDTH-1:0]   o_out_illegal,
   output logic [31:0]               o_out_pc
);

   logic [SlotBits-1:0]     w_dec_flat [DECODE_WIDTH];
   decoded_slot_t           r_data     [2][DECODE_WIDTH];
   logic [DECODE_WIDTH-1:0] r_sv       [2];
   logic [31:0]             r_pc       [2];
   logic [1:0]              r_count;
   logic                    r_wptr;
   logic                    r_rptr;
   logic                    w_push;
   logic                    w_pop;

   assign o_in_ready  = (r_count != 2'd2);
   assign o_out_valid = (r_count != 2'd0);
   // A bundle offered during flush is dropped, never stored
   assign w_push      = i_in_valid && o_in_ready && !i_flush;
   assign w_pop       = o_out_valid && i_out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 2'd0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
      end else if (i_flush) begin
         r_count <= 2'd0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
      end else begin
         r_wptr <= r_wptr ^ w_push;
         r_rptr <= r_rptr ^ w_pop;
         if (w_push && !w_pop) begin
            r_count <= r_count + 2'd1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 2'd1;
         end
      end
   end

   // Payload needs no reset: outputs are gated by out_valid
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_sv[r_wptr] <= i_in_slot_valid;
         r_pc[r_wptr] <= i_in_pc;
         for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
            r_data[r_wptr][i] <= decoded_slot_t'(w_dec_flat[i]);
         end
      end
   end

   assign o_out_pc = o_out_valid ? r_pc[r_rptr] : 32'd0;

   for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_slot
      decoded_slot_t w_head;

      slot_decoder #(
         .EXT_JUMPS (EXT_JUMPS)
      ) u_dec (
         .i_instr (i_in_instr[32*g +: 32]),
         .i_valid (i_in_slot_valid[g]),
         .o_slot  (w_dec_flat[g])
      );

      assign w_head                     = o_out_valid ? r_data[r_rptr][g] : '0;
      assign o_out_slot_valid[g]        = o_out_valid && r_sv[r_rptr][g];
      assign o_out_rs1[5*g +: 5]        = w_head.rs1;
      assign o_out_rs2[5*g +: 5]        = w_head.rs2;
      assign o_out_rd[5*g +: 5]         = w_head.rd;
      assign o_out_aluop[3*g +: 3]      = w_head.aluop;
      assign o_out_opcode[7*g +: 7]     = w_head.opcode;
      assign o_out_fu_alu[g]            = w_head.fu_alu;
      assign o_out_fu_mem[g]            = w_head.fu_mem;
      assign o_out_uses_rs1[g]          = w_head.uses_rs1;
      assign o_out_uses_rs2[g]          = w_head.uses_rs2;
      assign o_out_writes_rd[g]         = w_head.writes_rd;
      assign o_out_illegal[g]           = w_head.illegal;
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (EXT_JUMPS 0 and 1) share stimulus and are
// compared every cycle against a queue-based bundle model with a table-driven decoder.
module tb_decode_stage;

   localparam int unsigned W = 2;

   // Per-opcode table: opcode, ALUOp, use mask {rs1,rs2,rd}, mem, needs EXT_JUMPS
   localparam logic [6:0] T_OPC [9] = '{7'h13, 7'h37, 7'h33, 7'h03, 7'h23, 7'h63, 7'h67,
                                         7'h17, 7'h6F};
   localparam logic [2:0] T_ALU [9] = '{3'd3, 3'd4, 3'd2, 3'd0, 3'd0, 3'd1, 3'd6, 3'd5, 3'd7};
   localparam logic [2:0] T_USE [9] = '{3'b101, 3'b001, 3'b111, 3'b101, 3'b110, 3'b110,
                                         3'b101, 3'b001, 3'b001};
   localparam logic T_MEM [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic T_EXT [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   typedef struct {
      logic [31:0]    pc;
      logic [W-1:0]   sv;
      logic [32*W-1:0] instr;
   } bundle_t;

   logic clk = 1'b0;
   logic rst_n, flush, in_valid, out_ready;
   logic [32*W-1:0] in_instr;
   logic [W-1:0]    in_sv;
   logic [31:0]     in_pc;

   logic            in_ready  [2];
   logic            out_valid [2];
   logic [W-1:0]    o_sv  [2];
   logic [5*W-1:0]  rs1   [2];
   logic [5*W-1:0]  rs2   [2];
   logic [5*W-1:0]  rd    [2];
   logic [3*W-1:0]  aluop [2];
   logic [7*W-1:0]  opc   [2];
   logic [W-1:0]    fa    [2];
   logic [W-1:0]    fm    [2];
   logic [W-1:0]    u1    [2];
   logic [W-1:0]    u2    [2];
   logic [W-1:0]    wr    [2];
   logic [W-1:0]    ill   [2];
   logic [31:0]     opc_pc [2];

   int n_checks = 0;
   int n_errors = 0;
   bundle_t q[$];

   always #5 clk = ~clk;

   for (genvar d = 0; d < 2; d++) begin : g_dut
      decode_stage #(
         .DECODE_WIDTH (W),
         .EXT_JUMPS    (d)
      ) u_dut (
         .clk              (clk),
         .rst_n            (rst_n),
         .i_flush          (flush),
         .i_in_valid       (in_valid),
         .o_in_ready       (in_ready[d]),
         .i_in_instr       (in_instr),
         .i_in_slot_valid  (in_sv),
         .i_in_pc          (in_pc),
         .o_out_valid      (out_valid[d]),
         .i_out_ready      (out_ready),
         .o_out_slot_valid (o_sv[d]),
         .o_out_rs1        (rs1[d]),
         .o_out_rs2        (rs2[d]),
         .o_out_rd         (rd[d]),
         .o_out_aluop      (aluop[d]),
         .o_out_opcode     (opc[d]),
         .o_out_fu_alu     (fa[d]),
         .o_out_fu_mem     (fm[d]),
         .o_out_uses_rs1   (u1[d]),
         .o_out_uses_rs2   (u2[d]),
         .o_out_writes_rd  (wr[d]),
         .o_out_illegal    (ill[d]),
         .o_out_pc         (opc_pc[d])
      );
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   // Expected record, field order {rs1,rs2,rd,aluop,opcode,alu,mem,use1,use2,wr,illegal}
   function automatic logic [30:0] ref_slot(input logic [31:0] ins, input logic v, input int ext);
      logic [4:0] r1, r2, r3;
      if (!v) return '0;
      for (int k = 0; k < 9; k++) begin
         if (ins[6:0] == T_OPC[k] && (!T_EXT[k] || ext == 1)) begin
            r1 = T_USE[k][2] ? ins[19:15] : 5'd0;
            r2 = T_USE[k][1] ? ins[24:20] : 5'd0;
            r3 = T_USE[k][0] ? ins[11:7]  : 5'd0;
            return {r1, r2, r3, T_ALU[k], ins[6:0], 1'b1, T_MEM[k], T_USE[k][2], T_USE[k][1],
                    T_USE[k][0] && (r3 != 5'd0), 1'b0};
         end
      end
      return 31'd1;
   endfunction

   function automatic logic [30:0] obs_slot(input int d, input int s);
      return {rs1[d][5*s +: 5], rs2[d][5*s +: 5], rd[d][5*s +: 5], aluop[d][3*s +: 3],
              opc[d][7*s +: 7], fa[d][s], fm[d][s], u1[d][s], u2[d][s], wr[d][s], ill[d][s]};
   endfunction

   task automatic check_all();
      bundle_t b;
      for (int d = 0; d < 2; d++) begin
         chk("in_ready", 64'(in_ready[d]), 64'(q.size() < 2));
         chk("out_valid", 64'(out_valid[d]), 64'(q.size() > 0));
         if (q.size() > 0) begin
            b = q[0];
            chk("out_pc", 64'(opc_pc[d]), 64'(b.pc));
            chk("slot_valid", 64'(o_sv[d]), 64'(b.sv));
            for (int s = 0; s < int'(W); s++) begin
               chk("slot_fields", 64'(obs_slot(d, s)), 64'(ref_slot(b.instr[32*s +: 32], b.sv[s], d)));
            end
         end else begin
            chk("idle_pc", 64'(opc_pc[d]), 64'd0);
            chk("idle_sv", 64'(o_sv[d]), 64'd0);
            for (int s = 0; s < int'(W); s++) chk("idle_slot", 64'(obs_slot(d, s)), 64'd0);
         end
      end
   endtask

   task automatic model_update();
      bundle_t b;
      logic    push, pop;
      push = in_valid && (q.size() < 2) && !flush;
      pop  = (q.size() > 0) && out_ready;
      if (flush) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            b.pc = in_pc; b.sv = in_sv; b.instr = in_instr;
            q.push_back(b);
         end
      end
   endtask

   // Check before the edge, advance the model on it, leave time at edge+1
   task automatic cycle();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [W-1:0] sv, input logic [31:0] pc, input logic ordy,
                        input logic fl);
      in_valid = v; in_instr = {i1, i0}; in_sv = sv; in_pc = pc; out_ready = ordy; flush = fl;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 4) != 0) r[6:0] = T_OPC[$urandom_range(0, 8)];
      return r;
   endfunction

   task automatic rand_cycle(input int ordy_pct);
      drive($urandom_range(0, 3) != 0, rand_instr(), rand_instr(), W'($urandom),
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 99) < ordy_pct,
            $urandom_range(0, 19) == 0);
      cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'd0, 32'd0, '0, 32'd0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // addi x5,x1,10 / add x3,x1,x2
      drive(1'b1, 32'h00A08293, 32'h002081B3, 2'b11, 32'h40, 1'b1, 1'b0);
      cycle();
      chk("addi_rs1", 64'(rs1[0][4:0]), 64'd1);
      chk("addi_rd", 64'(rd[0][4:0]), 64'd5);
      chk("addi_aluop", 64'(aluop[0][2:0]), 64'd3);
      chk("addi_use_wr", 64'({u1[0][0], wr[0][0]}), 64'b11);
      chk("add_regs", 64'({rs1[0][9:5], rs2[0][9:5], rd[0][9:5]}), 64'({5'd1, 5'd2, 5'd3}));
      chk("add_aluop", 64'(aluop[0][5:3]), 64'd2);

      // sw x2,8(x1) plus all-ones word in a valid slot
      drive(1'b1, 32'h0020A423, 32'hFFFFFFFF, 2'b11, 32'h80, 1'b1, 1'b0);
      cycle();
      chk("sw_regs", 64'({rs1[0][4:0], rs2[0][4:0], rd[0][4:0]}), 64'({5'd1, 5'd2, 5'd0}));
      chk("sw_fu_wr", 64'({fa[0][0], fm[0][0], wr[0][0]}), 64'b110);
      chk("ill_valid", 64'(obs_slot(0, 1)), 64'd1);

      // Same word in an invalid slot
      drive(1'b1, 32'h0020A423, 32'hFFFFFFFF, 2'b01, 32'hC0, 1'b1, 1'b0);
      cycle();
      chk("ill_invalid", 64'(ill[0][1]), 64'd0);

      // JAL x1, 8
      drive(1'b1, 32'h008000EF, 32'h00000013, 2'b11, 32'hD0, 1'b1, 1'b0);
      cycle();
      chk("jal_ext0_ill", 64'(ill[0][0]), 64'd1);
      chk("jal_ext1", 64'({rd[1][4:0], aluop[1][2:0], wr[1][0], ill[1][0]}),
          64'({5'd1, 3'd7, 1'b1, 1'b0}));

      // Back-pressure
      drive(1'b0, 32'd0, 32'd0, 2'b00, 32'd0, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 32'h00A08293, 32'h002081B3, 2'b11, 32'h100, 1'b0, 1'b0);
      cycle();
      in_pc = 32'h108;
      cycle();
      chk("bp_full", 64'(in_ready[0]), 64'd0);
      in_pc = 32'h110;
      cycle();
      cycle();
      chk("bp_head", 64'(opc_pc[0]), 64'h100);
      out_ready = 1'b1;
      cycle();
      chk("order1", 64'(opc_pc[0]), 64'h108);
      chk("bp_reopen", 64'(in_ready[0]), 64'd1);
      cycle();
      chk("order2", 64'(opc_pc[0]), 64'h110);
      in_valid = 1'b0;
      cycle();

      // Flush with a full buffer and a bundle on offer
      drive(1'b1, 32'h00A08293, 32'h002081B3, 2'b11, 32'h200, 1'b0, 1'b0);
      cycle();
      in_pc = 32'h204;
      cycle();
      drive(1'b1, 32'h00A08293, 32'h002081B3, 2'b11, 32'h300, 1'b0, 1'b1);
      cycle();
      chk("flush_valid", 64'(out_valid[0]), 64'd0);
      chk("flush_ready", 64'(in_ready[0]), 64'd1);
      drive(1'b0, 32'd0, 32'd0, 2'b00, 32'd0, 1'b1, 1'b0);
      cycle();

      for (int n = 0; n < 400; n++) rand_cycle(75);

      // Fill up, then reset asynchronously between edges
      for (int n = 0; n < 6; n++) rand_cycle(10);
      rst_n = 1'b0;
      #2;
      q.delete();
      check_all();
      chk("rst_ready", 64'(in_ready[1]), 64'd1);
      rst_n = 1'b1;

      for (int n = 0; n < 200; n++) rand_cycle(60);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered decode stage between fetch and rename. Each cycle it accepts a bundle of up to DECODE_WIDTH RV32 instructions over a valid/ready handshake. Per slot it decodes register indices, ALUOp, functional-unit class, operand-use flags and an illegal-opcode flag. Decoded bundles are held in a 2-entry buffer, so fetch sees no combinational path from rename back-pressure and full throughput is sustained.

## Interface
Parameters:
- DECODE_WIDTH, 2, instructions per bundle (1..4)
- EXT_JUMPS, 0, 1 = also decode AUIPC and JAL; 0 = both are illegal

Ports (W = DECODE_WIDTH):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  fetch bundle valid
- in_ready  out  1  decode can accept a bundle
- in_instr  in  32*W  slot i at [32i+31:32i]
- in_slot_valid  in  W  per-slot valid
- in_pc  in  32  PC of slot 0; slot i PC = in_pc + 4i
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  rename accepts the bundle
- out_slot_valid  out  W  per-slot valid
- out_rs1, out_rs2, out_rd  out  5*W each  register indices
- out_aluop  out  3*W  ALU operation class
- out_opcode  out  7*W  raw opcode
- out_fu_alu, out_fu_mem  out  W each  FU class
- out_uses_rs1, out_uses_rs2, out_writes_rd  out  W each  operand-use flags
- out_illegal  out  W  unknown opcode in a valid slot
- out_pc  out  32  PC of slot 0

## Operation
- Per-slot decode, keyed on instr[6:0]:
  - OP-IMM 0010011: rs1, rd; ALUOp 011; alu
  - LUI 0110111: rd; ALUOp 100; alu
  - OP 0110011: rs1, rs2, rd; ALUOp 010; alu
  - LOAD 0000011: rs1, rd; ALUOp 000; alu+mem
  - STORE 0100011: rs1, rs2; ALUOp 000; alu+mem
  - BRANCH 1100011: rs1, rs2; ALUOp 001; alu
  - JALR 1100111: rs1, rd; ALUOp 110; alu
  - AUIPC 0010111 (EXT_JUMPS=1 only): rd; ALUOp 101; alu
  - JAL 1101111 (EXT_JUMPS=1 only): rd; ALUOp 111; alu
- Field rules:
  - Unused rs1/rs2/rd fields output 0.
  - uses_rs1/uses_rs2 are set exactly when the field is used.
  - writes_rd = (instruction writes rd) && rd != 0.
- Unknown opcode in a valid slot: all fields 0, fu 0, illegal=1.
- Invalid slot (in_slot_valid[i]=0): all per-slot outputs 0, including illegal.
- Buffer: 2-entry FIFO of decoded bundles with a 2-bit count.
  - in_ready = (count != 2), from registered state only.
  - out_valid = (count != 0); outputs come from the head entry.
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, pointers advance.
  - Pointers are 1 bit and wrap naturally.
- Flush has top priority: count and both pointers clear.
  - A bundle offered in the flush cycle is dropped.
  - A pop in the flush cycle is still considered consumed.

## Timing
- Latency: a bundle accepted at edge N appears on the outputs after edge N, if the buffer was empty.
- Throughput: one bundle per cycle while out_ready=1.
- Back-pressure: with out_ready=0, two bundles are accepted, then in_ready=0 in the following cycle.
  - in_ready returns to 1 the cycle after the first pop.
- Reset values: count=0, pointers=0, out_valid=0, in_ready=1, all data outputs 0.
- Reset mid-operation discards all buffered bundles immediately.
- Output data is stable while out_valid && !out_ready.

## Structure
- Package decode_pkg:
  - opcode localparams
  - ALUOp localparams
  - decoded_slot_t packed struct (rs1, rs2, rd, aluop, opcode, fu_alu, fu_mem, uses_rs1, uses_rs2, writes_rd, illegal)
- Sub-module slot_decoder: combinational, one instance per slot via generate, takes EXT_JUMPS.
- The top holds the FIFO storage (array of W decoded_slot_t plus slot_valid and pc per entry).

## Test plan
- addi x5,x1,10 (0x00A08293) in slot 0, add x3,x1,x2 (0x002081B3) in slot 1:
  - next cycle slot 0: rs1=1, rd=5, aluop=011, uses_rs1=1, writes_rd=1
  - slot 1: rs1=1, rs2=2, rd=3, aluop=010
- sw x2,8(x1) (0x0020A423):
  - rs1=1, rs2=2, rd=0, fu_alu=1, fu_mem=1, writes_rd=0
- 0xFFFFFFFF in a valid slot -> illegal=1, all other fields 0.
  - Same word with slot_valid=0 -> illegal=0.
- JAL 0x008000EF:
  - EXT_JUMPS=0 -> illegal=1
  - EXT_JUMPS=1 -> rd=1, aluop=111, writes_rd=1
- out_ready=0 for 4 cycles with in_valid=1 and PCs 0x100, 0x108, 0x110:
  - 0x100 and 0x108 accepted, in_ready=0 from the third cycle
  - after release, outputs in order 0x100, 0x108, 0x110
- Flush with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, offered bundle never appears.
- rst_n low mid-stream -> the same reset state.
